// File: rtl/spike_event_logger.sv
// Purpose : timestamps single-cycle spike pulses with a free-running sample
//           counter and buffers them in a DEPTH-entry FIFO for host readout.
// Latency : a spike sampled at edge k is visible on evt_valid/evt_ts after edge k.
// Backpr. : evt_valid/evt_ready handshake; when full without a pop, new events
//           are dropped and counted (drop_cnt saturates, overflow is sticky).
// Ports   : clk, rst_n (async active-low), clear (sync), sample_en (ts strobe),
//           spike_in (event pulse), evt_valid/evt_ready/evt_ts (readout),
//           fifo_level (occupancy 0..DEPTH), drop_cnt, overflow (status).
module spike_event_logger #(
   parameter int TS_WIDTH   = 24,
   parameter int DEPTH      = 8,   // power of two, >= 2
   parameter int DROP_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      sample_en,
   input  logic                      spike_in,
   output logic                      evt_valid,
   input  logic                      evt_ready,
   output logic [TS_WIDTH-1:0]       evt_ts,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic [DROP_WIDTH-1:0]     drop_cnt,
   output logic                      overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [TS_WIDTH-1:0]   ts_q, ts_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
   logic                  overflow_q, overflow_d;
   logic [TS_WIDTH-1:0]   mem_q [DEPTH];

   logic not_empty, full, pop, push_ok, drop;

   assign not_empty = (count_q != '0);
   assign full      = (count_q == LVL_FULL);

   // Clear wins over everything: spikes and pops in a clearing cycle are ignored.
   assign pop     = not_empty && evt_ready && !clear;
   // A full FIFO still accepts a write when the head leaves at the same edge.
   assign push_ok = spike_in && !clear && (!full || pop);
   assign drop    = spike_in && !clear && full && !pop;

   always_comb begin
      ts_d       = ts_q + TS_WIDTH'(sample_en);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;

      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;

      case ({push_ok, pop})
         2'b10:   count_d = count_q + LVL_ONE;
         2'b01:   count_d = count_q - LVL_ONE;
         default: count_d = count_q;
      endcase

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
      end

      if (clear) begin
         ts_d       = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         drop_cnt_d = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         ts_q       <= ts_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   // The captured value is ts_q, i.e. the timestamp before any same-edge increment.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= ts_q;
   end

   // All outputs come from registers only: no path from evt_ready.
   assign evt_valid  = not_empty;
   assign evt_ts     = not_empty ? mem_q[rd_ptr_q] : '0;
   assign fifo_level = count_q;
   assign drop_cnt   = drop_cnt_q;
   assign overflow   = overflow_q;

endmodule
